// File: rtl/iir_pkg.sv
// Shared definitions for the second-order IIR filter family: default
// coefficients, widths and the inverse filter's sequencing states.
package iir_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  // Default coefficients of the forward filter
  //   y = b0*x + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
  localparam int A1_DEF = 4;
  localparam int A2_DEF = 3;
  localparam int B0_DEF = 6;
  localparam int B1_DEF = 1;
  localparam int B2_DEF = 2;

  // Number of product terms summed into the numerator
  localparam int MAC_STEPS = 5;

  // Numerator accumulator width: a full product plus headroom for five terms
  function automatic int acc_width(input int dw);
    return 2 * dw + 4;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/iir_inverse_if.sv
// Input and output streams of the inverse filter. The master side feeds
// filtered samples and consumes recovered ones; the slave side is the block.
interface iir_inverse_if #(
  parameter int DATA_WIDTH = iir_pkg::DATA_WIDTH_DEF
) ();

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] y_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] x_out;
  logic                         inexact;
  logic                         sat;

  modport master (
    output in_valid, y_in, out_ready,
    input  in_ready, out_valid, x_out, inexact, sat
  );

  modport slave (
    input  in_valid, y_in, out_ready,
    output in_ready, out_valid, x_out, inexact, sat
  );

endinterface

// File: rtl/seq_divider.sv
// Serial signed divider: restoring division of the magnitudes, one quotient
// bit per cycle, signs applied on the way out (truncation toward zero, the
// remainder takes the dividend's sign).
module seq_divider #(
  parameter int DVD_W = 36,
  parameter int DVS_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [DVD_W-1:0] dividend,
  input  logic signed [DVS_W-1:0] divisor,
  output logic                    busy,
  output logic                    done,
  output logic signed [DVD_W:0]   quotient,
  output logic signed [DVS_W-1:0] remainder
);

  localparam int CW = $clog2(DVD_W);
  localparam logic [CW-1:0] LAST_STEP = CW'(DVD_W - 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    step_q, step_d;
  logic [DVD_W-1:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic [DVD_W-1:0] dvd_mag;
  logic [DVS_W-1:0] dvs_mag;
  logic [DVS_W:0]   trial;

  // The most negative value negates to itself, which is the right magnitude unsigned
  assign dvd_mag = dividend[DVD_W-1] ? -dividend : dividend;
  assign dvs_mag = divisor[DVS_W-1]  ? -divisor  : divisor;

  // Load on start, then one restoring subtract/shift step per cycle
  always_comb begin
    busy_d = busy_q;
    step_d = step_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    trial  = {rem_q, quo_q[DVD_W-1]};
    if (start) begin
      busy_d = 1'b1;
      step_d = '0;
      quo_d  = dvd_mag;
      rem_d  = '0;
      dvs_d  = dvs_mag;
      qneg_d = dividend[DVD_W-1] ^ divisor[DVS_W-1];
      rneg_d = dividend[DVD_W-1];
    end else if (busy_q) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = DVS_W'(trial - {1'b0, dvs_q});
        quo_d = {quo_q[DVD_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DVS_W-1:0];
        quo_d = {quo_q[DVD_W-2:0], 1'b0};
      end
      step_d = step_q + 1'b1;
      if (step_q == LAST_STEP) begin
        busy_d = 1'b0;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      step_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      step_q <= step_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

  // done marks the cycle whose edge writes the final quotient bit
  assign busy      = busy_q;
  assign done      = busy_q && (step_q == LAST_STEP);
  assign quotient  = qneg_q ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});
  assign remainder = rneg_q ? -$signed(rem_q) : $signed(rem_q);

endmodule

// File: rtl/iir_inverse.sv
// Inverse of the second-order IIR filter: rebuilds x[n] from y[n] with one
// shared multiplier for the numerator and a serial divider for the 1/b0 step.
module iir_inverse
  import iir_pkg::*;
#(
  parameter int                         DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic signed [DATA_WIDTH-1:0] A1 = DATA_WIDTH'(A1_DEF),
  parameter logic signed [DATA_WIDTH-1:0] A2 = DATA_WIDTH'(A2_DEF),
  parameter logic signed [DATA_WIDTH-1:0] B0 = DATA_WIDTH'(B0_DEF),
  parameter logic signed [DATA_WIDTH-1:0] B1 = DATA_WIDTH'(B1_DEF),
  parameter logic signed [DATA_WIDTH-1:0] B2 = DATA_WIDTH'(B2_DEF)
) (
  input  logic        clk,
  input  logic        rst,
  iir_inverse_if.slave bus
);

  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int QW         = ACC_WIDTH + 1;
  localparam logic [2:0] MAC_LAST = 3'(MAC_STEPS - 1);
  localparam logic signed [QW-1:0] X_MAX = QW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [QW-1:0] X_MIN = -X_MAX - 1;

  // Dividing by zero has no meaningful hardware behaviour; refuse to build
  generate
    if (B0 == 0) begin : g_bad_b0
      $error("iir_inverse: B0 must be nonzero");
    end
  endgenerate

  state_t state_q, state_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] y_lat_q, y_lat_d;
  logic signed [DATA_WIDTH-1:0] xn1_q, xn1_d, xn2_q, xn2_d;
  logic signed [DATA_WIDTH-1:0] yn1_q, yn1_d, yn2_q, yn2_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] x_out_q, x_out_d;
  logic                         inexact_q, inexact_d;
  logic                         sat_q, sat_d;
  logic                         out_valid_q, out_valid_d;

  logic signed [DATA_WIDTH-1:0] mul_a, mul_b;
  logic                         mac_sub;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;

  logic signed [DATA_WIDTH-1:0] x_sat;
  logic                         sat_flag;

  logic                         in_ready;
  logic                         div_start, div_busy, div_done;
  logic signed [QW-1:0]         div_quo;
  logic signed [DATA_WIDTH-1:0] div_rem;

  // Operand selection for the shared multiplier, one numerator term per MAC step
  always_comb begin
    mul_a   = y_lat_q;
    mul_b   = DATA_WIDTH'(1);
    mac_sub = 1'b0;
    case (cnt_q)
      3'd1: begin mul_a = yn1_q; mul_b = A1; end
      3'd2: begin mul_a = yn2_q; mul_b = A2; end
      3'd3: begin mul_a = xn1_q; mul_b = B1; mac_sub = 1'b1; end
      3'd4: begin mul_a = xn2_q; mul_b = B2; mac_sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = PROD_WIDTH'(mul_a) * PROD_WIDTH'(mul_b);
  assign prod_ext = ACC_WIDTH'(prod);

  // Clip the full-width quotient into the sample range
  always_comb begin
    x_sat    = DATA_WIDTH'(div_quo);
    sat_flag = 1'b0;
    if (div_quo > X_MAX) begin
      x_sat    = DATA_WIDTH'(X_MAX);
      sat_flag = 1'b1;
    end else if (div_quo < X_MIN) begin
      x_sat    = DATA_WIDTH'(X_MIN);
      sat_flag = 1'b1;
    end
  end

  assign in_ready = (state_q == ST_IDLE) && !div_busy;

  // Sequencing: accept, accumulate numerator, divide, fix up, hold for consumer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    y_lat_d     = y_lat_q;
    xn1_d       = xn1_q;
    xn2_d       = xn2_q;
    yn1_d       = yn1_q;
    yn2_d       = yn2_q;
    acc_d       = acc_q;
    x_out_d     = x_out_q;
    inexact_d   = inexact_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    div_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready) begin
          y_lat_d = bus.y_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = mac_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == MAC_LAST) begin
          // Divider loads the finished numerator on the same edge
          div_start = 1'b1;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        x_out_d     = x_sat;
        inexact_d   = (div_rem != '0);
        sat_d       = sat_flag;
        out_valid_d = 1'b1;
        // History keeps the clipped value so it tracks what was delivered
        xn2_d       = xn1_q;
        xn1_d       = x_sat;
        yn2_d       = yn1_q;
        yn1_d       = y_lat_q;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, history and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      y_lat_q     <= '0;
      xn1_q       <= '0;
      xn2_q       <= '0;
      yn1_q       <= '0;
      yn2_q       <= '0;
      acc_q       <= '0;
      x_out_q     <= '0;
      inexact_q   <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      y_lat_q     <= y_lat_d;
      xn1_q       <= xn1_d;
      xn2_q       <= xn2_d;
      yn1_q       <= yn1_d;
      yn2_q       <= yn2_d;
      acc_q       <= acc_d;
      x_out_q     <= x_out_d;
      inexact_q   <= inexact_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  seq_divider #(
    .DVD_W(ACC_WIDTH),
    .DVS_W(DATA_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc_d),
    .divisor  (B0),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_out_q;
  assign bus.inexact   = inexact_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_iir_inverse.sv
// Scoreboard bench for iir_inverse: stimulus pushes hand-computed results,
// per-instance monitors pop and compare on each output handshake.
module tb_iir_inverse;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iir_inverse_if #(.DATA_WIDTH(DW)) bus_a ();
  iir_inverse_if #(.DATA_WIDTH(DW)) bus_b ();

  // Default coefficients
  iir_inverse #(.DATA_WIDTH(DW)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  // b0 = 1 so large inputs can reach the saturation bound
  iir_inverse #(.DATA_WIDTH(DW), .B0(16'sd1)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  typedef struct {
    int x;
    bit inexact;
    bit sat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor for instance a
  always @(negedge clk) begin
    if (!rst && bus_a.out_valid && bus_a.out_ready) begin
      $display("txn a: x_out=%0d inexact=%0d sat=%0d", bus_a.x_out, bus_a.inexact, bus_a.sat);
      chk("sb_nonempty_a", int'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        ea = q_a.pop_front();
        chk("x_out_a", int'(bus_a.x_out), ea.x);
        chk("inexact_a", int'(bus_a.inexact), int'(ea.inexact));
        chk("sat_a", int'(bus_a.sat), int'(ea.sat));
      end
    end
  end

  // Monitor for instance b
  always @(negedge clk) begin
    if (!rst && bus_b.out_valid && bus_b.out_ready) begin
      $display("txn b: x_out=%0d inexact=%0d sat=%0d", bus_b.x_out, bus_b.inexact, bus_b.sat);
      chk("sb_nonempty_b", int'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        eb = q_b.pop_front();
        chk("x_out_b", int'(bus_b.x_out), eb.x);
        chk("inexact_b", int'(bus_b.inexact), int'(eb.inexact));
        chk("sat_b", int'(bus_b.sat), int'(eb.sat));
      end
    end
  end

  function automatic bit rdy(input bit b);
    return b ? bus_b.in_ready : bus_a.in_ready;
  endfunction

  task automatic drive_in(input bit b, input bit v, input int y);
    if (b) begin
      bus_b.in_valid = v;
      bus_b.y_in     = 16'(y);
    end else begin
      bus_a.in_valid = v;
      bus_a.y_in     = 16'(y);
    end
  endtask

  // Offer one sample; returns just after the accepting edge
  task automatic send(input bit b, input int y, input bit push,
                      input int ex, input bit exi, input bit exs);
    exp_t e;
    bit   got;
    int   n;
    if (push) begin
      e.x = ex; e.inexact = exi; e.sat = exs;
      if (b) q_b.push_back(e); else q_a.push_back(e);
    end
    @(posedge clk); #1;
    drive_in(b, 1'b1, y);
    got = 1'b0;
    n   = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = rdy(b);
      @(posedge clk); #1;
      n++;
    end
    drive_in(b, 1'b0, 0);
    chk("accept_in_time", int'(got), 1);
  endtask

  task automatic wait_valid_a(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (bus_a.out_valid) break;
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() + q_b.size()) > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q_a.size() + q_b.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int lat;
    bus_a.in_valid = 1'b0; bus_a.y_in = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.y_in = '0; bus_b.out_ready = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_out_valid_a", int'(bus_a.out_valid), 0);
    chk("rst_in_ready_a", int'(bus_a.in_ready), 1);
    chk("rst_x_out_a", int'(bus_a.x_out), 0);
    chk("rst_inexact_a", int'(bus_a.inexact), 0);
    chk("rst_sat_a", int'(bus_a.sat), 0);
    chk("rst_in_ready_b", int'(bus_b.in_ready), 1);
    chk("rst_out_valid_b", int'(bus_b.out_valid), 0);

    // 12/6 = 2 exact, with latency measured from the accepting edge
    send(1'b0, 12, 1'b1, 2, 1'b0, 1'b0);
    wait_valid_a(lat);
    chk("latency_a", lat, 42);
    drain();

    // Forward impulse response 6, -23, 76 recovers 1, 0, 0
    do_reset();
    send(1'b0, 6, 1'b1, 1, 1'b0, 1'b0);
    send(1'b0, -23, 1'b1, 0, 1'b0, 1'b0);
    send(1'b0, 76, 1'b1, 0, 1'b0, 1'b0);
    drain();

    // Truncation toward zero: 7/6 -> 1, -7/6 -> -1, both inexact
    do_reset();
    send(1'b0, 7, 1'b1, 1, 1'b1, 1'b0);
    drain();
    do_reset();
    send(1'b0, -7, 1'b1, -1, 1'b1, 1'b0);
    drain();

    // b0 = 1: 32767 passes, then numerator 131068 clips to 32767
    do_reset();
    send(1'b1, 32767, 1'b1, 32767, 1'b0, 1'b0);
    send(1'b1, 32767, 1'b1, 32767, 1'b0, 1'b1);
    drain();

    // Backpressure: output held stable, no new sample taken
    do_reset();
    bus_a.out_ready = 1'b0;
    send(1'b0, 12, 1'b1, 2, 1'b0, 1'b0);
    wait_valid_a(lat);
    chk("hold_reached", int'(bus_a.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus_a.in_valid = ~bus_a.in_valid;
      bus_a.y_in     = 16'($urandom);
      @(negedge clk);
      chk("hold_out_valid", int'(bus_a.out_valid), 1);
      chk("hold_x_out", int'(bus_a.x_out), 2);
      chk("hold_flags", int'({bus_a.inexact, bus_a.sat}), 0);
      chk("hold_in_ready", int'(bus_a.in_ready), 0);
    end
    @(posedge clk); #1;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_hold_in_ready", int'(bus_a.in_ready), 1);
    chk("post_hold_out_valid", int'(bus_a.out_valid), 0);
    // History holds only y=12,x=2: (0 + 4*12 - 2)/6 = 46/6 -> 7 rem 4
    send(1'b0, 0, 1'b1, 7, 1'b1, 1'b0);
    drain();

    // Reset mid-division abandons the sample and clears history
    send(1'b0, 12, 1'b0, 0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", int'(bus_a.out_valid), 0);
    chk("abort_in_ready", int'(bus_a.in_ready), 1);
    send(1'b0, 12, 1'b1, 2, 1'b0, 1'b0);
    drain();

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
